// File: rtl/load_store_unit_if.sv
// Request, response and data-memory bundle of the load/store unit.
// slave is the unit's view, master the pipeline-plus-memory view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, busy, mem_we, mem_re,
    output mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, busy, mem_we, mem_re,
    input  mem_addr, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store unit in front of a word memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW/SH/SW.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RSP
  } state_t;

  state_t state, state_nx;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        accept;
  logic        legal;
  logic        mis;
  logic        req_err;
  logic [31:0] word_idx;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state == IDLE) && bus.req_valid;

  // Legal funct3 per direction; misalignment only matters when trapping
  always_comb begin
    if (bus.req_we)
      legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101};
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((bus.req_funct3[1:0] == 2'b10) &&
           (bus.req_addr[1:0] != 2'b00)) ||
          ((bus.req_funct3[1:0] == 2'b01) &&
           bus.req_addr[0]);
`else
    mis = 1'b0;
`endif
    req_err = !legal || mis;
  end

  assign word_idx = {{(30-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    b_sel  = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
    h_sel  = bus.mem_rd[{addr_q[1], 4'b0000} +: 16];
    merged = bus.mem_rd;
    unique case (f3_q)
      3'b000:  load_val = {{24{b_sel[7]}}, b_sel};
      3'b001:  load_val = {{16{h_sel[15]}}, h_sel};
      3'b100:  load_val = {24'h0, b_sel};
      3'b101:  load_val = {16'h0, h_sel};
      default: load_val = bus.mem_rd;
    endcase
    if (f3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)
            state_nx = RSP;
          else if (bus.req_we && bus.req_funct3 == 3'b010)
            state_nx = WRITE;
          else
            state_nx = READ;
        end
      end
      READ:    state_nx = we_q ? WRITE : RSP;
      WRITE:   state_nx = RSP;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, then load result or merged store word from READ
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr[ADDR_W+1:0];
      word_q  <= bus.req_wdata;
      rdata_q <= 32'h0;
      err_q   <= req_err;
    end else if (state == READ) begin
      if (we_q) word_q  <= merged;
      else      rdata_q <= load_val;
    end
  end

  // Outputs by state, all forced low while reset is asserted
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;
    bus.rsp_err   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wd    = 32'h0;
    bus.busy      = (state != IDLE);
    unique case (state)
      IDLE: bus.req_ready = 1'b1;
      READ: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = word_idx;
      end
      WRITE: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = word_idx;
        bus.mem_wd   = word_q;
      end
      default: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
      end
    endcase
    if (!rst) begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = 32'h0;
      bus.rsp_err   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wd    = 32'h0;
      bus.busy      = 1'b0;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit that sits directly upstream of the word-addressed data memory and feeds its `MemWrite`/`MemRead`/`Data_Addr`/`WD` inputs while consuming `RD`. It converts byte addresses and RV32I `funct3` access types (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. It performs read-modify-write for sub-word stores and sign/zero-extends load data. A small FSM with a valid/ready request handshake stalls the pipeline through `busy` while an access is in flight.

## Interface
- `ADDR_W`, default 10: word-index width; memory depth is 2^ADDR_W words.
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I width/sign code.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, low-aligned.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  32: extended load data; 0 for stores and errors.
- `rsp_err`  out  1: qualifies `rsp_valid`; illegal or misaligned access.
- `busy`  out  1: transaction in flight, meaning the state is not IDLE.
- `mem_we`  out  1: drives memory `MemWrite`.
- `mem_re`  out  1: drives memory `MemRead`.
- `mem_addr`  out  32: word index `{zeros, req_addr[ADDR_W+1:2]}`.
- `mem_wd`  out  32: write word.
- `mem_rd`  in  32: memory read data, combinational from `mem_addr` when `mem_re` is high.

## Operation
- States: IDLE, READ, WRITE, RSP.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_we`, `req_funct3`, `req_addr`, and `req_wdata`, then branch:
  - Load, or SB/SH store: go to READ.
  - SW: go to WRITE.
  - Illegal or misaligned access: go to RSP with the error flag set; no memory access.
- READ: `mem_re`=1 and `mem_addr` is driven. Capture `mem_rd` at the clock edge.
  - Load: extract the data, then go to RSP.
  - SB/SH: merge the store data into the captured word, then go to WRITE.
- WRITE: `mem_we`=1, `mem_wd`=merged word (SB/SH) or `req_wdata` (SW). Next state is RSP.
- RSP: `rsp_valid`=1 for exactly one cycle, then go to IDLE. There is no back-pressure on the response.
- Legal `funct3` values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other value is illegal: `rsp_err`=1, `rsp_rdata`=0. This applies regardless of the configuration.
- Byte lane `k` = `addr[1:0]`, bits [8k+7:8k]. Half lane `h` = `addr[1]`, bits [16h+15:16h].
- Load extraction:
  - LB and LH sign-extend the selected lane.
  - LBU and LHU zero-extend the selected lane.
  - LW returns the whole word.
- Store merge:
  - SB replaces byte lane `k` with `wdata[7:0]`.
  - SH replaces half lane `h` with `wdata[15:0]`.
  - All other bits are preserved.
- Address bits above `ADDR_W+1` are dropped, so out-of-range addresses wrap.
- `mem_addr` and `mem_wd` are 0 whenever `mem_re` and `mem_we` are both low.

## Timing
- Request accepted in cycle N (IDLE, `req_valid`=1).
- Response latency:
  - Load: READ at N+1, `rsp_valid` at N+2.
  - SW: WRITE at N+1, `rsp_valid` at N+2.
  - SB/SH: READ at N+1, WRITE at N+2, `rsp_valid` at N+3.
  - Error: `rsp_valid` at N+1, with `mem_re` and `mem_we` never asserted.
- Next acceptance is no earlier than the cycle after RSP. `req_ready` is low in READ, WRITE and RSP.
- Reset (`rst`=0 sampled at an edge):
  - State goes to IDLE and all latched registers clear.
  - While `rst` is low, all outputs are combinationally gated to 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy`, `mem_we`, `mem_re`, `mem_addr`, `mem_wd`.
- Reset mid-operation: the in-flight transaction is dropped, with no response. A WRITE cycle coinciding with `rst`=0 performs no write, because `mem_we` is gated.
- `req_ready`=1 in the first cycle after `rst` returns high.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access is an error. Misaligned means LW/SW with `addr[1:0]`≠0, or LH/LHU/SH with `addr[0]`≠0. The unit responds at N+1 with `rsp_err`=1 and makes no memory access.
- `LSU_MISALIGN_TRAP_EN` undefined: the low address bits are silently masked and there is no error.
  - LW/SW ignore `addr[1:0]`.
  - LH/LHU/SH use `addr[1]` only.
  - Timing matches the aligned case.

## Test plan
- Word index 4 = 0x8BADF00D. LB at 0x13 gives `rsp_rdata`=0xFFFFFF8B at N+2; LBU at 0x13 gives 0x0000008B; LH at 0x12 gives 0xFFFF8BAD.
- Word index 4 = 0x11223344. SB at 0x11 with wdata 0x000000AA: `mem_we` high only at N+2, word becomes 0x1122AA44, `rsp_valid` at N+3 with `rsp_rdata`=0.
- SW at 0x20 with wdata 0xDEADBEEF (`mem_addr`=8 at N+1), then LW at 0x20 gives 0xDEADBEEF; `busy` is high N+1..N+2.
- LW at 0x22:
  - With the macro: `rsp_err`=1 at N+1, and `mem_re` and `mem_we` stay 0.
  - Without the macro: reads word 8, `rsp_err`=0 at N+2.
- Load with `funct3`=011 gives `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 at N+1.
- SH at 0x40 with `rst` driven low during its WRITE cycle: memory is unchanged, no `rsp_valid`, and `req_ready`=1 in the first cycle after `rst` goes high.
